multicycle_controller: RTL

Control FSM for the multicycle MIPS datapath. It replaces single-cycle opcode decoding with a sequenced state machine that shares one memory port and one ALU across cycles and stalls on a memory-ready handshake. Optional extended opcodes are enabled by a parameter, and a retired-instruction counter is included. It sits between the instruction register's opcode field and the multicycle datapath's muxes, write enables and ALU decoder.

---
 rtl/multicycle_controller.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Sequencing control FSM for the multicycle MIPS datapath; outputs decoded from state (plus mem_ready/opcode).
// Latency 2..5 cycles per instruction; FETCH, MEM_RD and MEM_WR stall while mem_ready is low.
module multicycle_controller #(
    parameter bit SUPPORT_EXT = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             branch,
    output logic             branch_ne,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dest,
    output logic             memtoreg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             imm_zext,
    output logic [1:0]       pc_src,
    output logic             illegal,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_R_EXEC  = 4'd6,
        S_ALU_WB  = 4'd7,
        S_BRANCH  = 4'd8,
        S_I_EXEC  = 4'd9,
        S_I_WB    = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            retired <= '0;
        end else begin
            state_q <= state_d;
            if (instr_done) retired <= retired + CNT_W'(1);
        end
    end

    assign state = state_q;

    always_comb begin
        state_d    = S_FETCH;
        pc_write   = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dest   = 1'b0;
        memtoreg   = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 3'b000;
        imm_zext   = 1'b0;
        pc_src     = 2'b00;
        illegal    = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // ALU precomputes PC + (imm << 2) so BRANCH can use ALUOut
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:    state_d = S_MEM_ADR;
                    OP_RTYPE:        state_d = S_R_EXEC;
                    OP_BEQ:          state_d = S_BRANCH;
                    OP_BNE:          state_d = SUPPORT_EXT ? S_BRANCH : S_FETCH;
                    OP_ADDI:         state_d = S_I_EXEC;
                    OP_ANDI, OP_ORI: state_d = SUPPORT_EXT ? S_I_EXEC : S_FETCH;
                    OP_J:            state_d = S_JUMP;
                    default:         state_d = S_FETCH;
                endcase
                illegal = (state_d == S_FETCH);
            end
            S_MEM_ADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                state_d  = mem_ready ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                memtoreg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
                state_d    = mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b010;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                reg_dest   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 3'b001;
                pc_src     = 2'b01;
                branch     = (opcode == OP_BEQ);
                branch_ne  = SUPPORT_EXT && (opcode == OP_BNE);
                instr_done = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (SUPPORT_EXT && opcode == OP_ANDI) begin
                    alu_op   = 3'b011;
                    imm_zext = 1'b1;
                end else if (SUPPORT_EXT && opcode == OP_ORI) begin
                    alu_op   = 3'b100;
                    imm_zext = 1'b1;
                end
                state_d = S_I_WB;
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                instr_done = 1'b1;
            end
            // Unused encodings recover to FETCH without counting as a retirement
            default: state_d = S_FETCH;
        endcase

        // Reset kills every strobe combinationally so an aborted access cannot commit
        if (rst) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            branch     = 1'b0;
            branch_ne  = 1'b0;
            illegal    = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule
